pc_sequencer: RTL and testbench

- Owns the program counter of the pipelined RV32I core and sequences every control transfer into it.
- Selects the next PC from pc+4, the JAL target, the JALR target or the conditional-branch target.
- Generates pipeline flush, handles stall and halt/resume, and keeps the conditional/unconditional transfer counters shown on the board display.
- Sits between the IF stage (drives instruction-memory address) and the EX stage (receives resolved transfers).

---
 rtl/cpu_pkg.sv | 11 +
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/JalDestCalculator.sv | 10 +
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants used by the fetch-side sequencing logic of the RV32I core.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALT
    } pc_state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the pipeline (EX/ID/hazard/board side) and the PC sequencer.
interface pc_sequencer_if
    import cpu_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) ();
    logic                 stall;
    logic                 jal_valid;
    logic [19:0]          jal_imm;
    logic [XLEN-1:0]      jal_pc;
    logic                 jalr_valid;
    logic [XLEN-1:0]      jalr_target;
    logic                 br_taken;
    logic [XLEN-1:0]      br_target;
    logic                 halt_req;
    logic                 resume;
    logic [XLEN-1:0]      pc;
    logic                 pc_valid;
    logic                 flush;
    logic                 halted;
    logic [CNT_WIDTH-1:0] cond_cnt;
    logic [CNT_WIDTH-1:0] uncond_cnt;

    // master is the pipeline side that resolves transfers; slave is the sequencer itself
    modport master (
        output stall, jal_valid, jal_imm, jal_pc, jalr_valid, jalr_target,
               br_taken, br_target, halt_req, resume,
        input  pc, pc_valid, flush, halted, cond_cnt, uncond_cnt
    );

    modport slave (
        input  stall, jal_valid, jal_imm, jal_pc, jalr_valid, jalr_target,
               br_taken, br_target, halt_req, resume,
        output pc, pc_valid, flush, halted, cond_cnt, uncond_cnt
    );
endinterface

// File: rtl/JalDestCalculator.sv
// JAL destination: the 20-bit J-type immediate encodes imm[20:1], so sign-extend, shift by one, add to the JAL's PC.
module JalDestCalculator
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] jal_pc,
    input  logic [19:0]     jal_imm,
    output logic [XLEN-1:0] jal_dest
);
    assign jal_dest = jal_pc + {{(XLEN-21){jal_imm[19]}}, jal_imm, 1'b0};
endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: picks pc+4 or a resolved transfer target, drives flush, stall/halt handling and transfer counters.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              CNT_WIDTH    = 16
) (
    input logic          clk,
    input logic          rst,
    pc_sequencer_if.slave bus
);
    localparam logic [2:0]           FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    pc_state_t            state;
    logic [2:0]           flush_cnt;
    logic [XLEN-1:0]      pc_q;
    logic [CNT_WIDTH-1:0] cond_q;
    logic [CNT_WIDTH-1:0] uncond_q;
    logic [XLEN-1:0]      jal_dest;
    logic [XLEN-1:0]      target;
    logic                 redirect;
    logic                 uncond_win;

    JalDestCalculator u_jal_dest (
        .jal_pc   (bus.jal_pc),
        .jal_imm  (bus.jal_imm),
        .jal_dest (jal_dest)
    );

    // jalr beats jal beats branch; a halted core ignores all transfer requests
    always_comb begin
        redirect   = 1'b0;
        uncond_win = 1'b0;
        target     = bus.br_target;
        if (state != HALT) begin
            redirect   = bus.jalr_valid | bus.jal_valid | bus.br_taken;
            uncond_win = bus.jalr_valid | bus.jal_valid;
        end
        if (bus.jalr_valid) begin
            target = bus.jalr_target & ~32'd1;
        end else if (bus.jal_valid) begin
            target = jal_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
            pc_q      <= RESET_PC;
            cond_q    <= '0;
            uncond_q  <= '0;
        end else begin
            case (state)
                HALT: begin
                    if (bus.resume) begin
                        state <= RUN;
                    end
                end
                default: begin
                    if (redirect) begin
                        pc_q      <= target;
                        flush_cnt <= FLUSH_RELOAD;
                        state     <= (FLUSH_RELOAD != 3'd0) ? FLUSH : RUN;
                        if (uncond_win) begin
                            if (uncond_q != '1) uncond_q <= uncond_q + CNT_ONE;
                        end else begin
                            if (cond_q != '1) cond_q <= cond_q + CNT_ONE;
                        end
                    end else if (bus.halt_req) begin
                        flush_cnt <= 3'd0;
                        state     <= HALT;
                    end else begin
                        if (!bus.stall) begin
                            pc_q <= pc_q + PC_STEP;
                        end
                        // the flush window keeps draining even while the hazard unit stalls fetch
                        if (state == FLUSH) begin
                            flush_cnt <= flush_cnt - 3'd1;
                            if (flush_cnt == 3'd1) state <= RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_valid   = (state != HALT);
    assign bus.halted     = (state == HALT);
    assign bus.flush      = redirect | (state == FLUSH);
    assign bus.cond_cnt   = cond_q;
    assign bus.uncond_cnt = uncond_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_pc_sequencer;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   bit   check_en = 1'b0;

   // behavioural model state
   logic [31:0] m_pc;
   bit          m_halt;
   int          m_fleft;
   int          m_cond;
   int          m_unc;

   pc_sequencer_if #(.CNT_WIDTH(16)) bus ();

   pc_sequencer #(
      .RESET_PC     (32'h0000_0000),
      .FLUSH_CYCLES (FC),
      .CNT_WIDTH    (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic s,
                                input logic jv, input logic [19:0] ji, input logic [31:0] jp,
                                input logic rv, input logic [31:0] rt,
                                input logic bt, input logic [31:0] bta,
                                input logic hr, input logic rs);
      @(negedge clk);
      rst             = r;
      bus.stall       = s;
      bus.jal_valid   = jv;
      bus.jal_imm     = ji;
      bus.jal_pc      = jp;
      bus.jalr_valid  = rv;
      bus.jalr_target = rt;
      bus.br_taken    = bt;
      bus.br_target   = bta;
      bus.halt_req    = hr;
      bus.resume      = rs;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 20'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
   endtask

   // model advances on every rising edge from the inputs held during that cycle
   always @(posedge clk) begin
      int off;
      if (rst) begin
         m_pc = 32'h0; m_halt = 0; m_fleft = 0; m_cond = 0; m_unc = 0;
      end else if (m_halt) begin
         if (bus.resume) m_halt = 0;
      end else if (bus.jalr_valid || bus.jal_valid || bus.br_taken) begin
         if (bus.jalr_valid) begin
            m_pc = (bus.jalr_target >> 1) << 1;
         end else if (bus.jal_valid) begin
            off = bus.jal_imm[19] ? int'(bus.jal_imm) - (1 << 20) : int'(bus.jal_imm);
            m_pc = bus.jal_pc + 32'(off * 2);
         end else begin
            m_pc = bus.br_target;
         end
         if (bus.jalr_valid || bus.jal_valid) begin
            if (m_unc < 16'hFFFF) m_unc++;
         end else begin
            if (m_cond < 16'hFFFF) m_cond++;
         end
         m_fleft = FC - 1;
      end else if (bus.halt_req) begin
         m_halt = 1; m_fleft = 0;
      end else begin
         if (!bus.stall) m_pc = m_pc + 32'd4;
         if (m_fleft > 0) m_fleft--;
      end
   end

   // compare process: every cycle after reset, once the inputs for the cycle have settled
   always @(negedge clk) begin
      if (check_en) begin
         #2;
         checkOutput("pc", bus.pc, m_pc);
         checkOutput("pc_valid", 32'(bus.pc_valid), 32'(!m_halt));
         checkOutput("halted", 32'(bus.halted), 32'(m_halt));
         checkOutput("flush", 32'(bus.flush),
                     32'(!m_halt && (m_fleft > 0 || bus.jalr_valid || bus.jal_valid || bus.br_taken)));
         checkOutput("cond_cnt", {16'h0, bus.cond_cnt}, 32'(m_cond));
         checkOutput("uncond_cnt", {16'h0, bus.uncond_cnt}, 32'(m_unc));
      end
   end

   initial begin
      applyStimulus(1, 0, 0, 20'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
      applyStimulus(1, 0, 0, 20'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
      check_en = 1'b1;

      // free-running fetch after reset
      for (int i = 0; i < 4; i++) begin
         idle();
         #3;
         checkOutput("lit_seq_pc", bus.pc, 32'(i * 4));
         checkOutput("lit_seq_flush", 32'(bus.flush), 32'd0);
      end
      checkOutput("lit_reset_cnt", {bus.cond_cnt, bus.uncond_cnt}, 32'h0);
      checkOutput("lit_reset_valid", 32'(bus.pc_valid), 32'd1);

      // JAL backwards by 4 from 0x0C
      applyStimulus(0, 0, 1, 20'hFFFFE, 32'h0C, 0, 32'h0, 0, 32'h0, 0, 0);
      #3;
      checkOutput("lit_jal_src_pc", bus.pc, 32'h10);
      checkOutput("lit_jal_flush0", 32'(bus.flush), 32'd1);
      idle();
      #3;
      checkOutput("lit_jal_pc", bus.pc, 32'h08);
      checkOutput("lit_jal_flush1", 32'(bus.flush), 32'd1);
      checkOutput("lit_jal_uncond", {16'h0, bus.uncond_cnt}, 32'd1);

      // JALR and branch together: JALR wins, bit 0 cleared
      applyStimulus(0, 0, 0, 20'h0, 32'h0, 1, 32'h101, 1, 32'h40, 0, 0);
      #3;
      checkOutput("lit_after_jal_flush", 32'(bus.flush), 32'd1);
      idle();
      #3;
      checkOutput("lit_jalr_pc", bus.pc, 32'h100);
      checkOutput("lit_jalr_cnts", {bus.cond_cnt, bus.uncond_cnt}, 32'h0000_0002);

      // stall at 0x20 with a branch arriving mid-stall
      applyStimulus(0, 0, 0, 20'h0, 32'h0, 1, 32'h20, 0, 32'h0, 0, 0);
      applyStimulus(1'b0, 1'b1, 0, 20'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
      #3;
      checkOutput("lit_stall0_pc", bus.pc, 32'h20);
      applyStimulus(0, 1, 0, 20'h0, 32'h0, 0, 32'h0, 1, 32'h80, 0, 0);
      #3;
      checkOutput("lit_stall1_pc", bus.pc, 32'h20);
      applyStimulus(0, 1, 0, 20'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
      #3;
      checkOutput("lit_stall_br_pc", bus.pc, 32'h80);
      checkOutput("lit_stall_cond", {16'h0, bus.cond_cnt}, 32'd1);
      idle();
      #3;
      checkOutput("lit_stall_release_pc", bus.pc, 32'h80);

      // halt at 0x30 while the previous redirect is still flushing
      applyStimulus(0, 0, 0, 20'h0, 32'h0, 1, 32'h30, 0, 32'h0, 0, 0);
      applyStimulus(0, 0, 0, 20'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0);
      #3;
      checkOutput("lit_halt_req_pc", bus.pc, 32'h30);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1'(i % 2), 1'(i % 3 == 0), 20'h00100, 32'h0, 1'(i == 5), 32'h400,
                       1, 32'h200 + 32'(i * 8), 1, 0);
         #3;
         checkOutput("lit_halt_pc", bus.pc, 32'h30);
         checkOutput("lit_halt_flags", {29'h0, bus.halted, bus.pc_valid, bus.flush}, 32'b100);
      end
      checkOutput("lit_halt_cnts", {bus.cond_cnt, bus.uncond_cnt}, 32'h0001_0004);
      applyStimulus(0, 0, 0, 20'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1);
      #3;
      checkOutput("lit_resume_halted", 32'(bus.halted), 32'd1);
      idle();
      #3;
      checkOutput("lit_run_pc", bus.pc, 32'h30);
      checkOutput("lit_run_valid", 32'(bus.pc_valid), 32'd1);
      idle();
      #3;
      checkOutput("lit_run_next_pc", bus.pc, 32'h34);

      // drive cond_cnt up to saturation with back-to-back taken branches
      for (int i = 0; i < 16'hFFFD; i++) begin
         applyStimulus(0, 0, 0, 20'h0, 32'h0, 0, 32'h0, 1, 32'h100, 0, 0);
      end
      applyStimulus(0, 0, 0, 20'h0, 32'h0, 0, 32'h0, 1, 32'h100, 0, 0);
      #3;
      checkOutput("lit_cond_fffe", {16'h0, bus.cond_cnt}, 32'h0000_FFFE);
      applyStimulus(0, 0, 0, 20'h0, 32'h0, 0, 32'h0, 1, 32'h100, 0, 0);
      #3;
      checkOutput("lit_cond_ffff", {16'h0, bus.cond_cnt}, 32'h0000_FFFF);
      applyStimulus(0, 0, 0, 20'h0, 32'h0, 0, 32'h0, 1, 32'h100, 0, 0);
      #3;
      checkOutput("lit_cond_sat", {16'h0, bus.cond_cnt}, 32'h0000_FFFF);

      // reset while flushing
      applyStimulus(1, 0, 0, 20'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
      idle();
      #3;
      checkOutput("lit_rst_flush", 32'(bus.flush), 32'd0);
      checkOutput("lit_rst_pc", bus.pc, 32'h0);
      checkOutput("lit_rst_cnts", {bus.cond_cnt, bus.uncond_cnt}, 32'h0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(1'($urandom_range(0, 199) == 0),
                       1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 4) == 0), 20'($urandom), $urandom,
                       1'($urandom_range(0, 5) == 0), $urandom,
                       1'($urandom_range(0, 4) == 0), $urandom,
                       1'($urandom_range(0, 11) == 0),
                       1'($urandom_range(0, 4) == 0));
      end
      idle();
      #4;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
